fmap_stream_reader: RTL and testbench

- Transmitter end of the raster pixel stream consumed by conv2d_kernel_size_3.
- Reads one IMG_WIDTH x IMG_HEIGHT feature map from a synchronous frame RAM (1-cycle read latency) in raster order and drives it onto valid/data.
- After the last pixel, holds valid high for IMG_WIDTH+1 extra flush cycles so the convolver drains its bottom row, then pulses done.
- Replaces hand-written testbench stimulus and sits between the layer buffer RAM and each conv2d instance.

---
 rtl/fmap_stream_reader_if.sv | 45 ++++
 rtl/fmap_stream_reader.sv | 207 ++++++++++++++++++++
 tb/tb_fmap_stream_reader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fmap_stream_reader_if.sv
// fmap_stream_reader_if
//   Bundles the control, frame-RAM read port and pixel-stream output of
//   fmap_stream_reader.
//   master : the reader (drives rd_en/rd_addr/valid_out/data_out/busy/done)
//   slave  : the environment (drives start/pause/rd_data)
//   Signals:
//     start, pause          control requests into the reader
//     rd_en, rd_addr        synchronous RAM read request
//     rd_data               RAM read data, valid the cycle after rd_en
//     valid_out, data_out   pixel stream toward the convolver
//     busy, done            frame status
//     last_out              final-pixel marker (only with READER_LAST_FLAG_EN)
interface fmap_stream_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic                  pause;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic                  done;
`ifdef READER_LAST_FLAG_EN
    logic                  last_out;
`endif

    modport master (
        input  start, pause, rd_data,
        output rd_en, rd_addr, valid_out, data_out, busy, done
`ifdef READER_LAST_FLAG_EN
        , output last_out
`endif
    );

    modport slave (
        output start, pause, rd_data,
        input  rd_en, rd_addr, valid_out, data_out, busy, done
`ifdef READER_LAST_FLAG_EN
        , input last_out
`endif
    );
endinterface

// File: rtl/fmap_stream_reader.sv
// fmap_stream_reader
//   Streams one IMG_WIDTH x IMG_HEIGHT feature map out of a synchronous frame
//   RAM (1-cycle read latency) in raster order, then appends IMG_WIDTH+1
//   flush beats of FLUSH_DATA so a downstream 3x3 convolver can drain its
//   bottom row, then pulses done.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    fmap_stream_reader_if.master (start/pause in, RAM read port,
//            valid_out/data_out stream, busy/done status)
//   Optional feature: define READER_LAST_FLAG_EN to add bus.last_out, high
//   with valid_out on the final image pixel only.
//   Pipeline: issue (rd_en) at t -> stage 1 (tag + RAM data) at t+1 ->
//   stage 2 (valid_out/data_out) at t+2.
module fmap_stream_reader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    IMG_WIDTH  = 56,
    parameter int                    IMG_HEIGHT = 56,
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    BASE_ADDR  = 0,
    parameter logic [DATA_WIDTH-1:0] FLUSH_DATA = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    fmap_stream_reader_if.master bus
);
    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_W = $clog2(NPIX + 1);
    localparam int FL_W  = $clog2(IMG_WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [FL_W-1:0]       flush_q, flush_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  iss_p1_q, iss_p1_d;
    logic                  flush_p1_q, flush_p1_d;
    logic                  vld_p2_q, vld_p2_d;
    logic [DATA_WIDTH-1:0] data_p2_q, data_p2_d;
`ifdef READER_LAST_FLAG_EN
    logic                  last_p1_q, last_p1_d;
    logic                  last_p2_q, last_p2_d;
`endif

    logic issue_pix;
    logic issue_flush;
    logic last_pix;
    logic last_flush;
    logic pipe_empty;
    logic rd_en_o;
    logic busy_o;
    logic done_o;

    assign last_pix   = (pix_q == PIX_W'(NPIX - 1));
    assign last_flush = (flush_q == FL_W'(IMG_WIDTH));
    // Nothing left in stage 1 or stage 2: the final beat has been presented.
    assign pipe_empty = !iss_p1_q && !vld_p2_q;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start)                  state_d = ST_READ;
            ST_READ:  if (issue_pix && last_pix)      state_d = ST_FLUSH;
            ST_FLUSH: if (issue_flush && last_flush)  state_d = ST_DONE;
            ST_DONE:  if (pipe_empty)                 state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. pause only gates issue in READ/FLUSH.
    always_comb begin
        issue_pix   = 1'b0;
        issue_flush = 1'b0;
        rd_en_o     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            ST_READ: begin
                busy_o    = 1'b1;
                issue_pix = !bus.pause;
                rd_en_o   = !bus.pause;
            end
            ST_FLUSH: begin
                busy_o      = 1'b1;
                issue_flush = !bus.pause;
            end
            ST_DONE: begin
                busy_o = 1'b1;
                done_o = pipe_empty;
            end
            default: ;
        endcase
    end

    // Pixel / flush counters and read address
    always_comb begin
        pix_d   = pix_q;
        flush_d = flush_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pix_d   = '0;
                    flush_d = '0;
                    addr_d  = BASE;
                end
            end
            ST_READ: begin
                if (issue_pix) begin
                    if (last_pix) begin
                        flush_d = '0;
                    end else begin
                        pix_d  = pix_q + PIX_W'(1);
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (issue_flush) flush_d = flush_q + FL_W'(1);
            end
            ST_DONE: begin
                pix_d   = '0;
                flush_d = '0;
                addr_d  = BASE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_q   <= '0;
            flush_q <= '0;
            addr_q  <= BASE;
        end else begin
            pix_q   <= pix_d;
            flush_q <= flush_d;
            addr_q  <= addr_d;
        end
    end

    // Stage 1: issue flag and pixel/flush tag, aligned with the RAM read
    always_comb begin
        iss_p1_d   = issue_pix || issue_flush;
        flush_p1_d = issue_flush;
`ifdef READER_LAST_FLAG_EN
        last_p1_d  = issue_pix && last_pix;
`endif
    end

    // Stage 2: registered stream output; data holds between beats
    always_comb begin
        vld_p2_d  = iss_p1_q;
        data_p2_d = data_p2_q;
        if (iss_p1_q) data_p2_d = flush_p1_q ? FLUSH_DATA : bus.rd_data;
`ifdef READER_LAST_FLAG_EN
        last_p2_d = iss_p1_q && last_p1_q && !flush_p1_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_p1_q   <= 1'b0;
            flush_p1_q <= 1'b0;
            vld_p2_q   <= 1'b0;
            data_p2_q  <= '0;
`ifdef READER_LAST_FLAG_EN
            last_p1_q  <= 1'b0;
            last_p2_q  <= 1'b0;
`endif
        end else begin
            iss_p1_q   <= iss_p1_d;
            flush_p1_q <= flush_p1_d;
            vld_p2_q   <= vld_p2_d;
            data_p2_q  <= data_p2_d;
`ifdef READER_LAST_FLAG_EN
            last_p1_q  <= last_p1_d;
            last_p2_q  <= last_p2_d;
`endif
        end
    end

    assign bus.rd_en     = rd_en_o;
    assign bus.rd_addr   = addr_q;
    assign bus.valid_out = vld_p2_q;
    assign bus.data_out  = data_p2_q;
    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
`ifdef READER_LAST_FLAG_EN
    assign bus.last_out  = last_p2_q;
`endif
endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader.
//   dut_a: 4x4 frame, BASE_ADDR=0, RAM[i]=i+1, FLUSH_DATA=0
//   dut_b: 3x2 frame, BASE_ADDR=100, RAM[a]=32'hA0000000|a, FLUSH_DATA=DEADBEEF
module tb_fmap_stream_reader;
    logic clk;
    logic reset;
    int   ncmp;
    int   nfail;

    fmap_stream_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus_a ();
    fmap_stream_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus_b ();

    fmap_stream_reader #(
        .DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4), .ADDR_WIDTH(12),
        .BASE_ADDR(0), .FLUSH_DATA(32'h00000000)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    fmap_stream_reader #(
        .DATA_WIDTH(32), .IMG_WIDTH(3), .IMG_HEIGHT(2), .ADDR_WIDTH(12),
        .BASE_ADDR(100), .FLUSH_DATA(32'hDEADBEEF)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous frame RAMs with one-cycle read latency
    always @(posedge clk) begin
        if (bus_a.rd_en) bus_a.rd_data <= 32'(bus_a.rd_addr) + 32'd1;
        if (bus_b.rd_en) bus_b.rd_data <= 32'hA000_0000 | 32'(bus_b.rd_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one 4x4 frame on dut_a. Called at a negedge; returns at a negedge.
    //   ps/pl : pause high during cycles ps..ps+pl-1 (pl=0: no pause)
    //   rs    : cycle at which start is re-pulsed (0: never)
    //   ab    : cycle at which reset is asserted (0: never)
    // Cycle 1 is the cycle after the edge that samples start.
    task automatic run_a(input int ps, input int pl, input int rs, input int ab);
        int   len;
        int   b;
        logic ev;
        len = 25 + pl;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        for (int c = 1; c <= len; c++) begin
            bus_a.pause = (pl > 0) && (c >= ps) && (c < ps + pl);
            bus_a.start = (c == rs);
            if (c == ab) begin
                reset = 1'b1;
                #1;
                chk($sformatf("abort_valid c%0d", c), 64'(bus_a.valid_out), 64'(0));
                chk($sformatf("abort_busy c%0d", c), 64'(bus_a.busy), 64'(0));
                chk($sformatf("abort_done c%0d", c), 64'(bus_a.done), 64'(0));
                chk($sformatf("abort_rd_en c%0d", c), 64'(bus_a.rd_en), 64'(0));
                chk($sformatf("abort_rd_addr c%0d", c), 64'(bus_a.rd_addr), 64'(0));
                @(negedge clk);
                chk("abort_valid_held", 64'(bus_a.valid_out), 64'(0));
                chk("abort_done_held", 64'(bus_a.done), 64'(0));
                reset = 1'b0;
                bus_a.pause = 1'b0;
                bus_a.start = 1'b0;
                break;
            end
            b  = 0;
            ev = 1'b0;
            if (c >= 3 && !((pl > 0) && (c >= ps + 2) && (c < ps + 2 + pl))) begin
                b  = ((pl > 0) && (c >= ps + 2 + pl)) ? c - 3 - pl : c - 3;
                ev = (b < 21);
            end
            @(negedge clk);
            chk($sformatf("a_valid c%0d", c), 64'(bus_a.valid_out), 64'(ev));
            if (ev)
                chk($sformatf("a_data c%0d beat%0d", c, b), 64'(bus_a.data_out),
                    64'((b < 16) ? b + 1 : 0));
`ifdef READER_LAST_FLAG_EN
            chk($sformatf("a_last c%0d", c), 64'(bus_a.last_out), 64'(ev && b == 15));
`endif
            chk($sformatf("a_done c%0d", c), 64'(bus_a.done), 64'(c == 24 + pl));
            chk($sformatf("a_busy c%0d", c), 64'(bus_a.busy), 64'(c <= 24 + pl));
            if (c < len) begin
                @(posedge clk); #1;
            end
        end
        bus_a.pause = 1'b0;
        bus_a.start = 1'b0;
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        reset = 1'b1;
        bus_a.start = 1'b0;
        bus_a.pause = 1'b0;
        bus_b.start = 1'b0;
        bus_b.pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_rd_en", 64'(bus_a.rd_en), 64'(0));
        chk("rst_rd_addr_a", 64'(bus_a.rd_addr), 64'(0));
        chk("rst_rd_addr_b", 64'(bus_b.rd_addr), 64'(100));
        chk("rst_valid", 64'(bus_a.valid_out), 64'(0));
        chk("rst_data", 64'(bus_a.data_out), 64'(0));
        chk("rst_busy", 64'(bus_a.busy), 64'(0));
        chk("rst_done", 64'(bus_a.done), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // pause in IDLE is ignored
        bus_a.pause = 1'b1;
        @(negedge clk);
        chk("idle_pause_busy", 64'(bus_a.busy), 64'(0));
        bus_a.pause = 1'b0;

        // Plain frame, then back-to-back frame with a start re-pulse mid-READ
        run_a(0, 0, 0, 0);
        run_a(0, 0, 8, 0);
        // Pause for 3 cycles after the 5th rd_en (cycle 5)
        run_a(6, 3, 0, 0);
        // Reset during FLUSH (cycle 19), then a fresh full frame
        run_a(0, 0, 0, 19);
        run_a(0, 0, 0, 0);

        // dut_b: 3x2 at BASE_ADDR=100 with a non-zero flush word
        @(negedge clk);
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            int   b;
            logic ev;
            b  = c - 3;
            ev = (c >= 3) && (b < 10);
            // rd_en/rd_addr are valid within the cycle they are issued
            chk($sformatf("b_rd_en c%0d", c), 64'(bus_b.rd_en), 64'(c <= 6));
            if (c <= 6)
                chk($sformatf("b_rd_addr c%0d", c), 64'(bus_b.rd_addr), 64'(99 + c));
            @(negedge clk);
            chk($sformatf("b_valid c%0d", c), 64'(bus_b.valid_out), 64'(ev));
            if (ev)
                chk($sformatf("b_data c%0d", c), 64'(bus_b.data_out),
                    (b < 6) ? 64'(32'hA000_0000 + 32'(100 + b)) : 64'(32'hDEADBEEF));
            chk($sformatf("b_done c%0d", c), 64'(bus_b.done), 64'(c == 13));
            @(posedge clk); #1;
        end
        // data_out holds its last value once the stream stops
        chk("b_data_hold", 64'(bus_b.data_out), 64'(32'hDEADBEEF));
        chk("b_idle_addr", 64'(bus_b.rd_addr), 64'(100));

        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
        $finish;
    end
endmodule
